// File: rtl/sprite_blitter.sv
`default_nettype none
// ============================================================================
//  Module   : sprite_blitter
//  Purpose  : Walks a SPR_W x SPR_H sprite ROM in row-major order and emits one
//             framebuffer write per clock. Off-screen pixels are clipped.
//             Background pixels can optionally be made transparent.
//  Revision : 1.0 - initial release
// ============================================================================
module sprite_blitter #(
  parameter int SPR_W       = 40,
  parameter int SPR_H       = 40,
  parameter int SCR_W       = 160,
  parameter int SCR_H       = 120,
  parameter int X_BITS      = 8,
  parameter int Y_BITS      = 7,
  parameter int COLOUR_BITS = 3,
  parameter int SEL_BITS    = 2,
  parameter int A_BITS      = $clog2(SPR_W * SPR_H)
) (
  input  logic                   CLOCK_50,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [SEL_BITS-1:0]    sel,
  input  logic [X_BITS-1:0]      x0,
  input  logic [Y_BITS-1:0]      y0,
  input  logic [COLOUR_BITS-1:0] fg_colour,
  input  logic [COLOUR_BITS-1:0] bg_colour,
  input  logic                   transparent,
  output logic [SEL_BITS-1:0]    rom_sel,
  output logic [A_BITS-1:0]      rom_addr,
  input  logic                   rom_q,
  output logic [X_BITS-1:0]      x,
  output logic [Y_BITS-1:0]      y,
  output logic [COLOUR_BITS-1:0] colour,
  output logic                   plot,
  output logic                   busy,
  output logic                   done
);

  localparam int I_BITS = (SPR_W > 1) ? $clog2(SPR_W) : 1;
  localparam int J_BITS = (SPR_H > 1) ? $clog2(SPR_H) : 1;
  localparam logic [A_BITS-1:0] c_last_addr = A_BITS'(SPR_W * SPR_H - 1);
  localparam logic [I_BITS-1:0] c_last_i    = I_BITS'(SPR_W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    FLUSH = 2'd2,
    FIN   = 2'd3
  } state_t;

  state_t                   state_q, state_d;
  logic [I_BITS-1:0]        i_q, i_d;
  logic [J_BITS-1:0]        j_q, j_d;
  logic [A_BITS-1:0]        addr_q, addr_d;
  logic                     w_accept;

  // Draw parameters captured at acceptance and held for the whole sprite
  logic [SEL_BITS-1:0]      sel_q;
  logic [X_BITS-1:0]        x0_q;
  logic [Y_BITS-1:0]        y0_q;
  logic [COLOUR_BITS-1:0]   fg_q, bg_q;
  logic                     transp_q;

  // Pixel stage: coordinates of the address issued one cycle earlier
  logic                     pv_q;
  logic [X_BITS:0]          sx_q;
  logic [Y_BITS:0]          sy_q;
  logic                     w_clip;

  // State and scan counters
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      i_q     <= '0;
      j_q     <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      addr_q  <= addr_d;
    end
  end

  // Next-state and counter stepping; the last address holds the counters
  always_comb begin
    state_d  = state_q;
    i_d      = i_q;
    j_d      = j_q;
    addr_d   = addr_q;
    w_accept = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          w_accept = 1'b1;
          state_d  = SCAN;
          i_d      = '0;
          j_d      = '0;
          addr_d   = '0;
        end
      end
      SCAN: begin
        if (addr_q == c_last_addr) begin
          state_d = FLUSH;
        end else begin
          addr_d = addr_q + A_BITS'(1);
          if (i_q == c_last_i) begin
            i_d = '0;
            j_d = j_q + J_BITS'(1);
          end else begin
            i_d = i_q + I_BITS'(1);
          end
        end
      end
      FLUSH:   state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Latch the draw request so later input changes cannot disturb it
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      sel_q    <= '0;
      x0_q     <= '0;
      y0_q     <= '0;
      fg_q     <= '0;
      bg_q     <= '0;
      transp_q <= 1'b0;
    end else if (w_accept) begin
      sel_q    <= sel;
      x0_q     <= x0;
      y0_q     <= y0;
      fg_q     <= fg_colour;
      bg_q     <= bg_colour;
      transp_q <= transparent;
    end
  end

  // Align screen coordinates with the ROM data that arrives a cycle later;
  // one extra bit keeps the sum from wrapping so clipping sees the true value
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      pv_q <= 1'b0;
      sx_q <= '0;
      sy_q <= '0;
    end else begin
      pv_q <= (state_q == SCAN);
      sx_q <= {1'b0, x0_q} + (X_BITS+1)'(i_q);
      sy_q <= {1'b0, y0_q} + (Y_BITS+1)'(j_q);
    end
  end

  // Output decode: clipping, transparency and colour select
  always_comb begin
    w_clip   = (sx_q >= (X_BITS+1)'(SCR_W)) || (sy_q >= (Y_BITS+1)'(SCR_H));
    x        = sx_q[X_BITS-1:0];
    y        = sy_q[Y_BITS-1:0];
    colour   = pv_q ? (rom_q ? bg_q : fg_q) : '0;
    plot     = pv_q & ~w_clip & ~(transp_q & rom_q);
    rom_addr = addr_q;
    rom_sel  = sel_q;
    busy     = (state_q != IDLE);
    done     = (state_q == FIN);
  end

endmodule
`default_nettype wire

// File: tb/tb_sprite_blitter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sprite_blitter
//  Purpose  : Scoreboard bench for sprite_blitter (4x2 sprite instance plus a
//             default-parameter instance for the full-size scan).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sprite_blitter;

  localparam int SW = 4;
  localparam int SH = 2;
  localparam int N  = SW * SH;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       start2 = 1'b0;
  logic [1:0] sel = 2'd0;
  logic [7:0] x0 = 8'd0;
  logic [6:0] y0 = 7'd0;
  logic [2:0] fg = 3'd0;
  logic [2:0] bg = 3'd0;
  logic       transp = 1'b0;

  logic [1:0] rom_sel;
  logic [2:0] rom_addr;
  logic       rom_q = 1'b0;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot, busy, done;

  logic [1:0]  rom_sel2;
  logic [10:0] rom_addr2;
  logic        rom_q2 = 1'b0;
  logic [7:0]  x2;
  logic [6:0]  y2;
  logic [2:0]  colour2;
  logic        plot2, busy2, done2;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pat = 0;

  typedef struct {
    int cyc;
    int px;
    int py;
    int col;
  } pix_t;

  pix_t exp_q[$];
  int   done_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous ROM model: pattern 1 gives rom_q=1 on even addresses
  always @(posedge clk) rom_q <= (pat == 1) ? ~rom_addr[0] : 1'b0;

  sprite_blitter #(.SPR_W(SW), .SPR_H(SH)) dut (
    .CLOCK_50(clk), .reset_n(rst_n), .start(start), .sel(sel), .x0(x0), .y0(y0),
    .fg_colour(fg), .bg_colour(bg), .transparent(transp),
    .rom_sel(rom_sel), .rom_addr(rom_addr), .rom_q(rom_q),
    .x(x), .y(y), .colour(colour), .plot(plot), .busy(busy), .done(done)
  );

  sprite_blitter dut2 (
    .CLOCK_50(clk), .reset_n(rst_n), .start(start2), .sel(sel), .x0(x0), .y0(y0),
    .fg_colour(fg), .bg_colour(bg), .transparent(transp),
    .rom_sel(rom_sel2), .rom_addr(rom_addr2), .rom_q(rom_q2),
    .x(x2), .y(y2), .colour(colour2), .plot(plot2), .busy(busy2), .done(done2)
  );

  // Monitor: every plot and done pulse is matched against the scoreboard
  always @(negedge clk) begin
    pix_t p;
    int   d;
    if (plot) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_plot got cyc=%0d (%0d,%0d) col=%0d want no plot",
                 cyc, x, y, colour);
      end else begin
        p = exp_q.pop_front();
        if (cyc != p.cyc || int'(x) != p.px || int'(y) != p.py || int'(colour) != p.col) begin
          errors++;
          $display("FAIL pixel got cyc=%0d (%0d,%0d) col=%0d want cyc=%0d (%0d,%0d) col=%0d",
                   cyc, x, y, colour, p.cyc, p.px, p.py, p.col);
        end
      end
    end
    if (done) begin
      checks++;
      if (done_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done got cyc=%0d want no done", cyc);
      end else begin
        d = done_q.pop_front();
        if (cyc != d) begin
          errors++;
          $display("FAIL done_cycle got %0d want %0d", cyc, d);
        end
      end
    end
  end

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  // Issue one draw and push the hand-derived expected pixels; only the first
  // 'cut' pixels are expected (a cut below N models an aborted draw)
  task automatic issue(input int xx, input int yy, input int f, input int b,
                       input int t, input int p, input int cut);
    int c0;
    @(negedge clk);
    pat    = p;
    x0     = 8'(xx);
    y0     = 7'(yy);
    fg     = 3'(f);
    bg     = 3'(b);
    transp = (t != 0);
    start  = 1'b1;
    c0     = cyc;
    for (int k = 0; k < cut; k++) begin
      int i, j, rq;
      i  = k % SW;
      j  = k / SW;
      rq = (p == 1) ? ((k % 2 == 0) ? 1 : 0) : 0;
      if (xx + i < 160 && yy + j < 120 && !(t != 0 && rq == 1))
        exp_q.push_back('{c0 + 2 + k, xx + i, yy + j, (rq == 1) ? b : f});
    end
    if (cut >= N) done_q.push_back(c0 + N + 2);
    @(negedge clk);
    start  = 1'b0;
    x0     = 8'd77;
    y0     = 7'd55;
    fg     = 3'd6;
    bg     = 3'd1;
    transp = ~transp;
  endtask

  initial begin
    int c0, bad_addr, bad_sel, nplot, done_at;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_plot", int'(plot), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_xy", int'({x, y}), 0);
    check("reset_colour", int'(colour), 0);
    check("reset_rom_addr", int'(rom_addr), 0);
    check("reset_rom_sel", int'(rom_sel), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Solid sprite at (10,20)
    issue(10, 20, 3'b010, 3'b111, 0, 0, N);
    repeat (N + 4) @(negedge clk);
    check("idle_busy_after_draw", int'(busy), 0);

    // Alternating pattern, opaque then transparent
    issue(10, 20, 3'b010, 3'b111, 0, 1, N);
    repeat (N + 4) @(negedge clk);
    issue(10, 20, 3'b010, 3'b111, 1, 1, N);
    repeat (N + 4) @(negedge clk);

    // Bottom-right corner clipping
    issue(158, 119, 3'b101, 3'b111, 0, 0, N);
    repeat (N + 4) @(negedge clk);

    // Start re-pulsed while busy is ignored
    issue(10, 20, 3'b011, 3'b111, 0, 0, N);
    @(negedge clk);
    check("busy_mid_draw", int'(busy), 1);
    x0    = 8'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (N + 4) @(negedge clk);

    // Reset in cycle 5 of a draw: three plots then nothing
    issue(10, 20, 3'b010, 3'b111, 0, 0, 3);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort_plot", int'(plot), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (N + 4) @(negedge clk);
    check("abort_idle_busy", int'(busy), 0);

    // Full draw after the aborted one
    issue(30, 40, 3'b100, 3'b001, 0, 0, N);
    repeat (N + 4) @(negedge clk);

    // Default-size instance: 40x40 scan with sel=2
    @(negedge clk);
    sel    = 2'd2;
    x0     = 8'd0;
    y0     = 7'd0;
    fg     = 3'd1;
    transp = 1'b0;
    start2 = 1'b1;
    c0     = cyc;
    @(negedge clk);
    start2   = 1'b0;
    sel      = 2'd0;
    bad_addr = 0;
    bad_sel  = 0;
    nplot    = 0;
    done_at  = -1;
    for (int k = 0; k < 1610; k++) begin
      if (k < 1600 && int'(rom_addr2) != k) bad_addr++;
      if (rom_sel2 != 2'd2) bad_sel++;
      if (plot2) nplot++;
      if (done2 && done_at < 0) done_at = cyc - c0;
      @(negedge clk);
    end
    check("big_addr_errors", bad_addr, 0);
    check("big_sel_errors", bad_sel, 0);
    check("big_plot_count", nplot, 1600);
    check("big_done_cycle", done_at, 1602);

    // Everything expected must have been seen
    check("pixels_left", exp_q.size(), 0);
    check("dones_left", done_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
